bram_pq_ctrl: RTL and testbench
===============================

# bram_pq_ctrl

Min-priority-queue controller for the BRAM tree: sits directly upstream of the single-port-pair BRAM store and owns all of its write/read ports. Enqueues land in the lowest free slot. A dequeue linearly scans every slot through the BRAM's 1-cycle registered read, returns the minimum valid entry, and writes the all-ones empty value back to that slot. Slot occupancy is tracked in an internal bitmap, so an all-ones data value is a legal key.

## Interface
- DATA_WIDTH, 32, key width; must match the BRAM.
- RAM_DEPTH, 256, number of slots (≥2); ADDR_W = $clog2(RAM_DEPTH), CNT_W = $clog2(RAM_DEPTH+1).
- CLK  in  1  clock; all state changes on rising edge.
- RSTn  in  1  reset, asynchronous, active-low.
- i_enq  in  1  enqueue request.
- i_enq_data  in  DATA_WIDTH  key to enqueue.
- i_deq  in  1  dequeue-min request.
- o_ready  out  1  controller idle; requests are sampled only when high.
- o_deq_valid  out  1  one-cycle pulse; o_deq_data holds the dequeued minimum.
- o_deq_data  out  DATA_WIDTH  last dequeued key; held until the next dequeue completes.
- o_count  out  CNT_W  number of occupied slots.
- o_full  out  1  o_count == RAM_DEPTH.
- o_empty  out  1  o_count == 0.
- o_ram_write  out  1  BRAM write strobe.
- o_ram_wrt_addr  out  ADDR_W  BRAM write address; integrator zero-extends it to the BRAM port.
- o_ram_data  out  DATA_WIDTH  BRAM write data.
- o_ram_read  out  1  BRAM read strobe.
- o_ram_read_addr  out  ADDR_W  BRAM read address; zero-extended by the integrator.
- i_ram_data  in  DATA_WIDTH  BRAM registered read data; valid the cycle after o_ram_read.

## Operation
- States: IDLE, SCAN, DRAIN, DONE.
- Occupancy is tracked in a RAM_DEPTH-bit bitmap. The free slot is the lowest index with a clear bit (priority encoder).
- IDLE:
  - o_ready = 1.
  - Dequeue accepted when i_deq && !o_empty.
  - Enqueue accepted when i_enq && !o_full && !(dequeue accepted). Dequeue wins over a simultaneous enqueue, and the enqueue is dropped (not queued).
- Enqueue, single cycle:
  - Drive o_ram_write = 1, o_ram_wrt_addr = free slot, o_ram_data = i_enq_data.
  - Set the bitmap bit and increment the count. Stay in IDLE.
- Dequeue acceptance cycle:
  - Drive o_ram_read = 1 with read address 0.
  - Set the scan address counter to 1 and the min-valid flag to 0. Go to SCAN.
- SCAN:
  - Each cycle, read the scan address, then increment it.
  - Compare i_ram_data for address (scan addr − 1). It is a candidate only if its bitmap bit is set.
  - Candidate replaces the current minimum if the min-valid flag is 0 or the value is strictly less, unsigned. Ties therefore keep the lower address.
  - After issuing the read of address RAM_DEPTH−1, go to DRAIN.
- DRAIN: no read; compare the data for address RAM_DEPTH−1. Go to DONE.
- DONE:
  - Pulse o_deq_valid; o_deq_data = minimum value.
  - Drive o_ram_write = 1, o_ram_wrt_addr = min address, o_ram_data = all ones.
  - Clear the bitmap bit and decrement the count. Go to IDLE.
- o_ready = 0 in SCAN, DRAIN and DONE. i_enq and i_deq are ignored there; no buffering.
- o_empty is checked at acceptance and the bitmap cannot change during a scan, so at least one candidate always exists.
- A write and a read are never issued to the same address in the same cycle.

## Timing
- Reset values:
  - State IDLE, bitmap 0, o_count 0, o_empty 1, o_full 0, o_ready 1.
  - o_deq_valid 0, o_deq_data 0.
  - All o_ram_* outputs 0.
- The BRAM resets itself to all ones independently.
- Enqueue: written to the BRAM at the end of the acceptance cycle; o_count updates the next cycle.
- Dequeue latency: acceptance at cycle T; o_deq_valid at T+RAM_DEPTH+1; o_ready high again at T+RAM_DEPTH+2.
- o_count decrements, and the freed slot is reusable, from T+RAM_DEPTH+2.
- Reset asserted mid-scan aborts immediately: no o_deq_valid, bitmap cleared, and BRAM contents are restored to all ones by the BRAM's own reset.
- All outputs except the o_ram_* strobes and addresses in IDLE are register-driven. The IDLE o_ram_* outputs are combinational from i_enq, i_deq and state.

## Test plan
- Reset: o_ready=1, o_empty=1, o_count=0. Assert i_deq while empty: no state change, no o_ram_read, o_deq_valid never asserts.
- Basic dequeue, RAM_DEPTH=8:
  - Enqueue 5, 3, 9: writes to addresses 0, 1, 2; o_count=3.
  - Dequeue accepted at T: o_deq_valid at T+9 with 3, and a write of 0xFFFFFFFF to address 1.
  - Next enqueue of 4 lands at address 1.
- Ties and all-ones key:
  - Enqueue 7, 7, 0xFFFFFFFF.
  - Dequeue returns 7 and frees address 0, then 7 freeing address 1, then 0xFFFFFFFF. o_empty=1 after the third.
- Full, RAM_DEPTH=8:
  - Eight enqueues: o_full=1.
  - A ninth i_enq: no o_ram_write, o_count stays 8.
  - One dequeue, then an enqueue: it lands in the freed slot.
- Contention:
  - i_enq and i_deq in the same IDLE cycle, queue non-empty: dequeue taken, no write that cycle.
  - i_enq asserted throughout SCAN: ignored; o_count is unchanged apart from the dequeue.
- Reset mid-scan: assert RSTn=0 at T+4. All outputs return to reset values; no o_deq_valid pulse; a subsequent enqueue goes to address 0.

Source files
------------

// File: rtl/bram_pq_ctrl.sv
// Min-priority-queue controller in front of a BRAM store with a 1-cycle registered read port.
// Enqueues fill the lowest free slot. A dequeue scans every slot, returns the minimum and empties that slot.
module bram_pq_ctrl #(
  parameter  int DATA_WIDTH = 32,
  parameter  int RAM_DEPTH  = 256,
  localparam int ADDR_W     = $clog2(RAM_DEPTH),
  localparam int CNT_W      = $clog2(RAM_DEPTH + 1)
) (
  input  logic                  CLK,
  input  logic                  RSTn,
  input  logic                  i_enq,
  input  logic [DATA_WIDTH-1:0] i_enq_data,
  input  logic                  i_deq,
  output logic                  o_ready,
  output logic                  o_deq_valid,
  output logic [DATA_WIDTH-1:0] o_deq_data,
  output logic [CNT_W-1:0]      o_count,
  output logic                  o_full,
  output logic                  o_empty,
  output logic                  o_ram_write,
  output logic [ADDR_W-1:0]     o_ram_wrt_addr,
  output logic [DATA_WIDTH-1:0] o_ram_data,
  output logic                  o_ram_read,
  output logic [ADDR_W-1:0]     o_ram_read_addr,
  input  logic [DATA_WIDTH-1:0] i_ram_data,
  output logic [1:0]            o_dbg_state
);

  // Handshake: i_enq/i_deq are sampled only in a cycle where o_ready is high; a request
  // that is not accepted in that cycle is dropped, never buffered. o_deq_valid is a
  // single-cycle pulse with no back-pressure; o_deq_data holds until the next dequeue.
  typedef enum logic [1:0] {IDLE = 2'd0, SCAN = 2'd1, DRAIN = 2'd2, DONE = 2'd3} state_t;

  state_t                state_q, state_d;
  logic [RAM_DEPTH-1:0]  bitmap_q;
  logic [CNT_W-1:0]      count_q, count_d;
  logic                  full_q, empty_q, ready_q;
  logic [ADDR_W-1:0]     scan_addr_q, min_addr_q;
  logic [DATA_WIDTH-1:0] min_val_q, deq_data_q;
  logic                  min_valid_q, deq_valid_q;

  logic                  deq_acc, enq_acc, take, last_read, comparing;
  logic [ADDR_W-1:0]     free_slot, cmp_addr, best_addr;
  logic [DATA_WIDTH-1:0] best_val;

  // Lowest clear bitmap index; the downward loop lets the lowest match win.
  always_comb begin
    free_slot = '0;
    for (int i = RAM_DEPTH - 1; i >= 0; i--) begin
      if (!bitmap_q[i]) free_slot = ADDR_W'(i);
    end
  end

  assign deq_acc   = (state_q == IDLE) && i_deq && !empty_q;
  assign enq_acc   = (state_q == IDLE) && i_enq && !full_q && !deq_acc;
  assign comparing = (state_q == SCAN) || (state_q == DRAIN);
  // Read data lags the address by one cycle; in DRAIN this wraps to RAM_DEPTH-1.
  assign cmp_addr  = scan_addr_q - ADDR_W'(1);
  assign last_read = (scan_addr_q == ADDR_W'(RAM_DEPTH - 1));
  assign take      = comparing && bitmap_q[cmp_addr] &&
                     (!min_valid_q || (i_ram_data < min_val_q));
  assign best_val  = take ? i_ram_data : min_val_q;
  assign best_addr = take ? cmp_addr : min_addr_q;

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (deq_acc) state_d = SCAN;
      SCAN:    if (last_read) state_d = DRAIN;
      DRAIN:   state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    count_d = count_q;
    if (enq_acc) count_d = count_q + CNT_W'(1);
    else if (state_q == DONE) count_d = count_q - CNT_W'(1);
  end

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      state_q     <= IDLE;
      bitmap_q    <= '0;
      count_q     <= '0;
      full_q      <= 1'b0;
      empty_q     <= 1'b1;
      ready_q     <= 1'b1;
      scan_addr_q <= '0;
      min_addr_q  <= '0;
      min_val_q   <= '0;
      min_valid_q <= 1'b0;
      deq_valid_q <= 1'b0;
      deq_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      full_q      <= (count_d == CNT_W'(RAM_DEPTH));
      empty_q     <= (count_d == '0);
      ready_q     <= (state_d == IDLE);
      deq_valid_q <= (state_q == DRAIN);
      if (state_q == DRAIN) deq_data_q <= best_val;
      if (enq_acc) bitmap_q[free_slot] <= 1'b1;
      else if (state_q == DONE) bitmap_q[min_addr_q] <= 1'b0;
      if (deq_acc) begin
        scan_addr_q <= ADDR_W'(1);
        min_valid_q <= 1'b0;
      end else if (comparing) begin
        if (state_q == SCAN) scan_addr_q <= scan_addr_q + ADDR_W'(1);
        min_val_q   <= best_val;
        min_addr_q  <= best_addr;
        min_valid_q <= min_valid_q | take;
      end
    end
  end

  // IDLE port activity is combinational from the requests; DONE writes back the empty value.
  always_comb begin
    o_ram_write     = enq_acc || (state_q == DONE);
    o_ram_wrt_addr  = '0;
    o_ram_data      = '0;
    if (state_q == DONE) begin
      o_ram_wrt_addr = min_addr_q;
      o_ram_data     = '1;
    end else if (enq_acc) begin
      o_ram_wrt_addr = free_slot;
      o_ram_data     = i_enq_data;
    end
    o_ram_read      = deq_acc || (state_q == SCAN);
    o_ram_read_addr = (state_q == SCAN) ? scan_addr_q : '0;
  end

  assign o_ready     = ready_q;
  assign o_deq_valid = deq_valid_q;
  assign o_deq_data  = deq_data_q;
  assign o_count     = count_q;
  assign o_full      = full_q;
  assign o_empty     = empty_q;
  assign o_dbg_state = state_q;

endmodule

// File: tb/tb_bram_pq_ctrl.sv
// Bench for bram_pq_ctrl with an 8-slot BRAM model and a slot-array reference model.
// Reference: lowest free slot on enqueue, minimum value (lowest index on ties) on dequeue.
module tb_bram_pq_ctrl;
  localparam int DW = 32;
  localparam int DEPTH = 8;
  localparam int AW = 3;
  localparam int CW = 4;

  logic          CLK = 1'b0;
  logic          RSTn = 1'b0;
  logic          i_enq = 1'b0, i_deq = 1'b0;
  logic [DW-1:0] i_enq_data = '0;
  logic          o_ready, o_deq_valid, o_full, o_empty, o_ram_write, o_ram_read;
  logic [DW-1:0] o_deq_data, o_ram_data, i_ram_data;
  logic [CW-1:0] o_count;
  logic [AW-1:0] o_ram_wrt_addr, o_ram_read_addr;
  logic [1:0]    o_dbg_state;

  int checks = 0;
  int errors = 0;

  always #5 CLK = ~CLK;

  bram_pq_ctrl #(.DATA_WIDTH(DW), .RAM_DEPTH(DEPTH)) dut (
    .CLK(CLK), .RSTn(RSTn), .i_enq(i_enq), .i_enq_data(i_enq_data), .i_deq(i_deq),
    .o_ready(o_ready), .o_deq_valid(o_deq_valid), .o_deq_data(o_deq_data),
    .o_count(o_count), .o_full(o_full), .o_empty(o_empty),
    .o_ram_write(o_ram_write), .o_ram_wrt_addr(o_ram_wrt_addr), .o_ram_data(o_ram_data),
    .o_ram_read(o_ram_read), .o_ram_read_addr(o_ram_read_addr), .i_ram_data(i_ram_data),
    .o_dbg_state(o_dbg_state)
  );

  // BRAM: resets to all ones, registered read.
  logic [DW-1:0] ram [DEPTH];
  logic [DW-1:0] ram_q;
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      for (int i = 0; i < DEPTH; i++) ram[i] <= '1;
      ram_q <= '1;
    end else begin
      if (o_ram_write) ram[o_ram_wrt_addr] <= o_ram_data;
      if (o_ram_read) ram_q <= ram[o_ram_read_addr];
    end
  end
  assign i_ram_data = ram_q;

  // Reference model
  bit            m_used [DEPTH];
  logic [DW-1:0] m_val [DEPTH];
  int            m_cnt;

  task automatic m_clear();
    for (int i = 0; i < DEPTH; i++) m_used[i] = 1'b0;
    m_cnt = 0;
  endtask

  task automatic m_enq(input logic [DW-1:0] d, output int idx);
    idx = -1;
    for (int i = DEPTH - 1; i >= 0; i--) if (!m_used[i]) idx = i;
    if (idx >= 0) begin
      m_used[idx] = 1'b1;
      m_val[idx] = d;
      m_cnt++;
    end
  endtask

  task automatic m_deq(output int idx, output logic [DW-1:0] v);
    idx = -1;
    v = '0;
    for (int i = 0; i < DEPTH; i++)
      if (m_used[i] && (idx < 0 || m_val[i] < m_val[idx])) idx = i;
    if (idx >= 0) begin
      v = m_val[idx];
      m_used[idx] = 1'b0;
      m_cnt--;
    end
  endtask

  // Driver tasks
  task automatic apply_reset();
    i_enq = 1'b0;
    i_deq = 1'b0;
    i_enq_data = '0;
    RSTn = 1'b0;
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    RSTn = 1'b1;
    m_clear();
  endtask

  task automatic drive_enq(input logic [DW-1:0] d, output logic wr, output logic [AW-1:0] wa,
                           output logic [DW-1:0] wd, output logic [CW-1:0] cnt);
    @(negedge CLK);
    i_enq = 1'b1;
    i_enq_data = d;
    #1;
    wr = o_ram_write;
    wa = o_ram_wrt_addr;
    wd = o_ram_data;
    @(posedge CLK);
    #1;
    i_enq = 1'b0;
    cnt = o_count;
  endtask

  task automatic drive_deq(output logic got, output int lat, output logic [DW-1:0] data,
                           output logic wr, output logic [AW-1:0] wa, output logic [DW-1:0] wd,
                           output logic rd0, output logic rdy, output logic [CW-1:0] cnt);
    @(negedge CLK);
    i_deq = 1'b1;
    #1;
    rd0 = o_ram_read;
    @(posedge CLK);
    #1;
    i_deq = 1'b0;
    got = 1'b0; lat = 0; data = '0; wr = 1'b0; wa = '0; wd = '0;
    for (int c = 1; c <= DEPTH + 8; c++) begin
      @(negedge CLK);
      if (o_deq_valid) begin
        got = 1'b1; lat = c; data = o_deq_data;
        wr = o_ram_write; wa = o_ram_wrt_addr; wd = o_ram_data;
        break;
      end
    end
    @(negedge CLK);
    rdy = o_ready;
    cnt = o_count;
  endtask

  // Shared scratch for the tests (only one test runs at a time)
  logic          s_wr, s_got, s_rd0, s_rdy;
  logic [AW-1:0] s_wa;
  logic [DW-1:0] s_wd, s_data, e_val;
  logic [CW-1:0] s_cnt;
  int            s_lat, e_idx;

  task automatic test_reset();
    apply_reset();
    @(negedge CLK);
    checks++;
    if (o_ready !== 1'b1 || o_empty !== 1'b1 || o_full !== 1'b0 || o_count !== '0 ||
        o_dbg_state !== 2'd0) begin
      errors++;
      $display("FAIL reset_status: ready=%b empty=%b full=%b count=%0d state=%0d, required 1 1 0 0 0",
               o_ready, o_empty, o_full, o_count, o_dbg_state);
    end
    checks++;
    if (o_deq_valid !== 1'b0 || o_deq_data !== '0 || o_ram_write !== 1'b0 || o_ram_read !== 1'b0 ||
        o_ram_wrt_addr !== '0 || o_ram_read_addr !== '0 || o_ram_data !== '0) begin
      errors++;
      $display("FAIL reset_outputs: deq_valid=%b deq_data=%h write=%b read=%b data=%h, required all zero",
               o_deq_valid, o_deq_data, o_ram_write, o_ram_read, o_ram_data);
    end
    for (int c = 0; c < 4; c++) begin
      i_deq = 1'b1;
      #1;
      checks++;
      if (o_ram_read !== 1'b0 || o_ready !== 1'b1 || o_deq_valid !== 1'b0 || o_dbg_state !== 2'd0) begin
        errors++;
        $display("FAIL deq_when_empty: read=%b ready=%b deq_valid=%b state=%0d, required 0 1 0 0",
                 o_ram_read, o_ready, o_deq_valid, o_dbg_state);
      end
      @(negedge CLK);
    end
    i_deq = 1'b0;
  endtask

  task automatic test_basic();
    logic [DW-1:0] vals [3];
    vals = '{32'd5, 32'd3, 32'd9};
    apply_reset();
    for (int k = 0; k < 3; k++) begin
      m_enq(vals[k], e_idx);
      drive_enq(vals[k], s_wr, s_wa, s_wd, s_cnt);
      checks++;
      if (s_wr !== 1'b1 || s_wa !== AW'(e_idx) || s_wd !== vals[k] || s_cnt !== CW'(m_cnt)) begin
        errors++;
        $display("FAIL basic_enq%0d: wr=%b addr=%0d data=%0d count=%0d, required 1 %0d %0d %0d",
                 k, s_wr, s_wa, s_wd, s_cnt, e_idx, vals[k], m_cnt);
      end
    end
    m_deq(e_idx, e_val);
    drive_deq(s_got, s_lat, s_data, s_wr, s_wa, s_wd, s_rd0, s_rdy, s_cnt);
    checks++;
    if (s_rd0 !== 1'b1 || s_got !== 1'b1 || s_lat != DEPTH + 1) begin
      errors++;
      $display("FAIL basic_deq_latency: read0=%b valid=%b latency=%0d, required 1 1 %0d",
               s_rd0, s_got, s_lat, DEPTH + 1);
    end
    checks++;
    if (s_data !== e_val || s_wr !== 1'b1 || s_wa !== AW'(e_idx) || s_wd !== '1) begin
      errors++;
      $display("FAIL basic_deq_result: data=%0d wr=%b addr=%0d wdata=%h, required %0d 1 %0d ffffffff",
               s_data, s_wr, s_wa, s_wd, e_val, e_idx);
    end
    checks++;
    if (s_rdy !== 1'b1 || s_cnt !== CW'(m_cnt)) begin
      errors++;
      $display("FAIL basic_after_deq: ready=%b count=%0d, required 1 %0d", s_rdy, s_cnt, m_cnt);
    end
    m_enq(32'd4, e_idx);
    drive_enq(32'd4, s_wr, s_wa, s_wd, s_cnt);
    checks++;
    if (s_wr !== 1'b1 || s_wa !== AW'(e_idx) || s_cnt !== CW'(m_cnt)) begin
      errors++;
      $display("FAIL basic_reuse_slot: wr=%b addr=%0d count=%0d, required 1 %0d %0d",
               s_wr, s_wa, s_cnt, e_idx, m_cnt);
    end
  endtask

  task automatic test_ties();
    logic [DW-1:0] vals [3];
    vals = '{32'd7, 32'd7, 32'hFFFF_FFFF};
    apply_reset();
    for (int k = 0; k < 3; k++) begin
      m_enq(vals[k], e_idx);
      drive_enq(vals[k], s_wr, s_wa, s_wd, s_cnt);
    end
    for (int k = 0; k < 3; k++) begin
      m_deq(e_idx, e_val);
      drive_deq(s_got, s_lat, s_data, s_wr, s_wa, s_wd, s_rd0, s_rdy, s_cnt);
      checks++;
      if (s_got !== 1'b1 || s_data !== e_val || s_wa !== AW'(e_idx) || s_cnt !== CW'(m_cnt)) begin
        errors++;
        $display("FAIL ties_deq%0d: valid=%b data=%h addr=%0d count=%0d, required 1 %h %0d %0d",
                 k, s_got, s_data, s_wa, s_cnt, e_val, e_idx, m_cnt);
      end
    end
    checks++;
    if (o_empty !== 1'b1) begin
      errors++;
      $display("FAIL ties_empty: empty=%b, required 1", o_empty);
    end
  endtask

  task automatic test_full();
    logic [DW-1:0] v;
    apply_reset();
    for (int k = 0; k < DEPTH; k++) begin
      v = DW'($urandom);
      m_enq(v, e_idx);
      drive_enq(v, s_wr, s_wa, s_wd, s_cnt);
    end
    checks++;
    if (o_full !== 1'b1 || o_count !== CW'(DEPTH)) begin
      errors++;
      $display("FAIL full_flag: full=%b count=%0d, required 1 %0d", o_full, o_count, DEPTH);
    end
    drive_enq(32'h1234, s_wr, s_wa, s_wd, s_cnt);
    checks++;
    if (s_wr !== 1'b0 || s_cnt !== CW'(DEPTH)) begin
      errors++;
      $display("FAIL full_enq_dropped: wr=%b count=%0d, required 0 %0d", s_wr, s_cnt, DEPTH);
    end
    m_deq(e_idx, e_val);
    drive_deq(s_got, s_lat, s_data, s_wr, s_wa, s_wd, s_rd0, s_rdy, s_cnt);
    checks++;
    if (s_got !== 1'b1 || s_data !== e_val || s_wa !== AW'(e_idx) || o_full !== 1'b0) begin
      errors++;
      $display("FAIL full_deq: valid=%b data=%h addr=%0d full=%b, required 1 %h %0d 0",
               s_got, s_data, s_wa, o_full, e_val, e_idx);
    end
    v = DW'($urandom);
    m_enq(v, e_idx);
    drive_enq(v, s_wr, s_wa, s_wd, s_cnt);
    checks++;
    if (s_wr !== 1'b1 || s_wa !== AW'(e_idx) || s_cnt !== CW'(DEPTH)) begin
      errors++;
      $display("FAIL full_refill: wr=%b addr=%0d count=%0d, required 1 %0d %0d",
               s_wr, s_wa, s_cnt, e_idx, DEPTH);
    end
  endtask

  task automatic test_contention();
    int stray;
    apply_reset();
    for (int k = 0; k < 3; k++) begin
      m_enq(DW'(10 * (k + 1)), e_idx);
      drive_enq(DW'(10 * (k + 1)), s_wr, s_wa, s_wd, s_cnt);
    end
    m_deq(e_idx, e_val);
    @(negedge CLK);
    i_enq = 1'b1;
    i_deq = 1'b1;
    i_enq_data = 32'd1;
    #1;
    checks++;
    if (o_ram_write !== 1'b0 || o_ram_read !== 1'b1) begin
      errors++;
      $display("FAIL contention_accept: write=%b read=%b, required 0 1", o_ram_write, o_ram_read);
    end
    @(posedge CLK);
    #1;
    i_deq = 1'b0;
    stray = 0;
    s_got = 1'b0;
    s_lat = 0;
    for (int c = 1; c <= DEPTH + 8; c++) begin
      @(negedge CLK);
      if (o_deq_valid) begin
        s_got = 1'b1; s_lat = c; s_data = o_deq_data;
        i_enq = 1'b0;
        break;
      end
      if (o_ram_write || o_ready) stray++;
    end
    i_enq = 1'b0;
    checks++;
    if (s_got !== 1'b1 || s_lat != DEPTH + 1 || s_data !== e_val || stray != 0) begin
      errors++;
      $display("FAIL contention_scan: valid=%b latency=%0d data=%0d stray=%0d, required 1 %0d %0d 0",
               s_got, s_lat, s_data, stray, DEPTH + 1, e_val);
    end
    @(negedge CLK);
    checks++;
    if (o_count !== CW'(m_cnt)) begin
      errors++;
      $display("FAIL contention_count: count=%0d, required %0d", o_count, m_cnt);
    end
  endtask

  task automatic test_reset_mid_scan();
    int seen;
    apply_reset();
    for (int k = 0; k < 3; k++) begin
      m_enq(DW'($urandom_range(1, 1000)), e_idx);
      drive_enq(m_val[e_idx], s_wr, s_wa, s_wd, s_cnt);
    end
    m_deq(e_idx, e_val);
    drive_deq(s_got, s_lat, s_data, s_wr, s_wa, s_wd, s_rd0, s_rdy, s_cnt);
    @(negedge CLK);
    i_deq = 1'b1;
    @(posedge CLK);
    #1;
    i_deq = 1'b0;
    repeat (4) @(negedge CLK);
    RSTn = 1'b0;
    #1;
    checks++;
    if (o_ready !== 1'b1 || o_empty !== 1'b1 || o_count !== '0 || o_deq_valid !== 1'b0 ||
        o_deq_data !== '0 || o_ram_write !== 1'b0 || o_ram_read !== 1'b0 ||
        o_ram_read_addr !== '0 || o_ram_wrt_addr !== '0 || o_ram_data !== '0) begin
      errors++;
      $display("FAIL midscan_reset_outputs: ready=%b empty=%b count=%0d deq_valid=%b deq_data=%h read=%b raddr=%0d",
               o_ready, o_empty, o_count, o_deq_valid, o_deq_data, o_ram_read, o_ram_read_addr);
    end
    @(negedge CLK);
    RSTn = 1'b1;
    m_clear();
    seen = 0;
    for (int c = 0; c < DEPTH + 4; c++) begin
      @(negedge CLK);
      if (o_deq_valid) seen++;
    end
    checks++;
    if (seen != 0) begin
      errors++;
      $display("FAIL midscan_no_valid: pulses=%0d, required 0", seen);
    end
    m_enq(32'd77, e_idx);
    drive_enq(32'd77, s_wr, s_wa, s_wd, s_cnt);
    checks++;
    if (s_wr !== 1'b1 || s_wa !== AW'(e_idx) || s_cnt !== CW'(1)) begin
      errors++;
      $display("FAIL midscan_enq_addr: wr=%b addr=%0d count=%0d, required 1 %0d 1", s_wr, s_wa, s_cnt, e_idx);
    end
  endtask

  task automatic test_random();
    logic [DW-1:0] v;
    apply_reset();
    for (int op = 0; op < 60; op++) begin
      if ($urandom_range(0, 2) != 0) begin
        v = ($urandom_range(0, 4) == 0) ? 32'hFFFF_FFFF : DW'($urandom_range(0, 20));
        m_enq(v, e_idx);
        drive_enq(v, s_wr, s_wa, s_wd, s_cnt);
        checks++;
        if (s_wr !== (e_idx >= 0) || (e_idx >= 0 && (s_wa !== AW'(e_idx) || s_wd !== v)) ||
            s_cnt !== CW'(m_cnt)) begin
          errors++;
          $display("FAIL rand_enq op%0d: wr=%b addr=%0d data=%h count=%0d, required slot %0d data %h count %0d",
                   op, s_wr, s_wa, s_wd, s_cnt, e_idx, v, m_cnt);
        end
      end else begin
        m_deq(e_idx, e_val);
        drive_deq(s_got, s_lat, s_data, s_wr, s_wa, s_wd, s_rd0, s_rdy, s_cnt);
        checks++;
        if (e_idx < 0) begin
          if (s_rd0 !== 1'b0 || s_got !== 1'b0 || s_cnt !== '0) begin
            errors++;
            $display("FAIL rand_deq_empty op%0d: read=%b valid=%b count=%0d, required 0 0 0",
                     op, s_rd0, s_got, s_cnt);
          end
        end else if (s_got !== 1'b1 || s_lat != DEPTH + 1 || s_data !== e_val ||
                     s_wa !== AW'(e_idx) || s_wd !== '1 || s_rdy !== 1'b1 || s_cnt !== CW'(m_cnt)) begin
          errors++;
          $display("FAIL rand_deq op%0d: valid=%b lat=%0d data=%h addr=%0d count=%0d, required 1 %0d %h %0d %0d",
                   op, s_got, s_lat, s_data, s_wa, s_cnt, DEPTH + 1, e_val, e_idx, m_cnt);
        end
      end
    end
  endtask

  initial begin
    m_clear();
    test_reset();
    test_basic();
    test_ties();
    test_full();
    test_contention();
    test_reset_mid_scan();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
